// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the cpu_ctrl sequencer: widths, opcodes, ALU select codes,
// FSM states and the decoded-instruction record.
package cpu_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = DATA_W - 3;

    typedef enum logic [2:0] {
        OP_LDA  = 3'b000,
        OP_TSTZ = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SHL  = 3'b100,
        OP_JZ   = 3'b101,
        OP_STA  = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    // Must agree with the select codes understood by alu.
    localparam logic [2:0] ALU_SEL_PASS = 3'b000;
    localparam logic [2:0] ALU_SEL_ZERO = 3'b001;
    localparam logic [2:0] ALU_SEL_ADD  = 3'b010;
    localparam logic [2:0] ALU_SEL_SUB  = 3'b011;
    localparam logic [2:0] ALU_SEL_SHL  = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_OPERAND = 3'd3,
        S_EXEC    = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    typedef struct packed {
        logic       needs_operand;
        logic       needs_wb;
        logic [2:0] alu_sel;
        logic       is_store;
        logic       is_jump;
        logic       is_halt;
    } dec_t;

endpackage

// File: rtl/cpu_ctrl_if.sv
// Bus bundle between cpu_ctrl and its environment (control, RAM and alu).
interface cpu_ctrl_if;
    import cpu_ctrl_pkg::*;

    logic              start;
    logic              busy;
    logic              halted;
    logic [DATA_W-1:0] acc;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              alu_en;
    logic [2:0]        alu_sel;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zero;

    modport master (
        input  start, mem_rdata, alu_out, alu_zero,
        output busy, halted, acc, mem_addr, mem_re, mem_we, mem_wdata,
               alu_en, alu_sel, alu_in1, alu_in2
    );

    modport slave (
        output start, mem_rdata, alu_out, alu_zero,
        input  busy, halted, acc, mem_addr, mem_re, mem_we, mem_wdata,
               alu_en, alu_sel, alu_in1, alu_in2
    );

endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode decoder: classifies an opcode into the sequencing and ALU controls.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0] op,
    output dec_t       dec
);

    always_comb begin
        dec = '0;
        case (opcode_t'(op))
            OP_LDA:  begin dec.needs_operand = 1'b1; dec.needs_wb = 1'b1; dec.alu_sel = ALU_SEL_PASS; end
            OP_TSTZ: begin dec.needs_wb = 1'b1; dec.alu_sel = ALU_SEL_ZERO; end
            OP_ADD:  begin dec.needs_operand = 1'b1; dec.needs_wb = 1'b1; dec.alu_sel = ALU_SEL_ADD; end
            OP_SUB:  begin dec.needs_operand = 1'b1; dec.needs_wb = 1'b1; dec.alu_sel = ALU_SEL_SUB; end
            OP_SHL:  begin dec.needs_wb = 1'b1; dec.alu_sel = ALU_SEL_SHL; end
            OP_JZ:   dec.is_jump  = 1'b1;
            OP_STA:  dec.is_store = 1'b1;
            OP_HALT: dec.is_halt  = 1'b1;
            default: dec = '0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer: owns PC, IR, accumulator and zero flag,
// and drives the shared RAM and the alu from the current state and IR.
module cpu_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    cpu_ctrl_if.master bus
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg;
    logic [DATA_W-1:0] ir_reg;
    logic [DATA_W-1:0] acc_reg;
    logic              z_reg;

    opcode_t           op_ir;
    logic [ADDR_W-1:0] opd;
    logic [2:0]        op_dec;
    dec_t              dec;

    assign op_ir = opcode_t'(ir_reg[DATA_W-1:ADDR_W]);
    assign opd   = ir_reg[ADDR_W-1:0];

    // In DECODE the instruction is still on mem_rdata; ir holds it only from the next cycle.
    assign op_dec = (state_reg == S_DECODE) ? bus.mem_rdata[DATA_W-1:ADDR_W]
                                            : ir_reg[DATA_W-1:ADDR_W];

    cpu_ctrl_decode u_decode (
        .op  (op_dec),
        .dec (dec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg  <= '0;
            ir_reg  <= '0;
            acc_reg <= '0;
            z_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        pc_reg  <= '0;
                        acc_reg <= '0;
                        z_reg   <= 1'b0;
                    end
                end
                S_DECODE: begin
                    ir_reg <= bus.mem_rdata;
                    pc_reg <= pc_reg + ADDR_W'(1);
                end
                S_EXEC: begin
                    if (dec.is_jump && z_reg) pc_reg <= opd;
                end
                S_WB: begin
                    if (op_ir == OP_TSTZ) z_reg   <= bus.alu_zero;
                    else                  acc_reg <= bus.alu_out;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_HALT: if (bus.start) state_next = S_FETCH;
            S_FETCH:   state_next = S_DECODE;
            S_DECODE:  state_next = dec.needs_operand ? S_OPERAND : S_EXEC;
            S_OPERAND: state_next = S_EXEC;
            S_EXEC: begin
                if (dec.needs_wb)     state_next = S_WB;
                else if (dec.is_halt) state_next = S_HALT;
                else                  state_next = S_FETCH;
            end
            S_WB:      state_next = S_FETCH;
            default:   state_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_re    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        bus.alu_en    = 1'b0;
        bus.alu_sel   = ALU_SEL_PASS;
        bus.alu_in1   = '0;
        bus.alu_in2   = '0;
        case (state_reg)
            S_FETCH: begin
                bus.mem_addr = pc_reg;
                bus.mem_re   = 1'b1;
            end
            S_OPERAND: begin
                bus.mem_addr = opd;
                bus.mem_re   = 1'b1;
            end
            S_EXEC: begin
                if (dec.needs_wb) begin
                    bus.alu_en  = 1'b1;
                    bus.alu_sel = dec.alu_sel;
                    bus.alu_in1 = (op_ir == OP_LDA) ? bus.mem_rdata : acc_reg;
                    if (op_ir == OP_ADD || op_ir == OP_SUB) bus.alu_in2 = bus.mem_rdata;
                    else if (op_ir == OP_SHL)               bus.alu_in2 = DATA_W'(opd);
                end
                if (dec.is_store) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = opd;
                    bus.mem_wdata = acc_reg;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy   = (state_reg != S_IDLE) && (state_reg != S_HALT);
    assign bus.halted = (state_reg == S_HALT);
    assign bus.acc    = acc_reg;

endmodule
